// File: rtl/sample_seq.sv
// sample_seq: streams a ramp or LFSR burst to a run detector and checks its count.
// Ports: clk, rst_n, go, mode, thresh, seed, N_abv in; sig, strtCapCmp, sig_vld, busy, done, result, exp_cnt, mismatch out.
module sample_seq #(
  parameter int LEN    = 16,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       mode,
  input  logic [7:0] thresh,
  input  logic [7:0] seed,
  input  logic [7:0] N_abv,
  output logic [7:0] sig,
  output logic       strtCapCmp,
  output logic       sig_vld,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] exp_cnt,
  output logic       mismatch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_STREAM,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [7:0] LEN_M1 = 8'(LEN - 1);
  // A zero settle time still spends one cycle in SETTLE so exp_cnt is final.
  localparam logic [7:0] SET_M1 = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;

  state_t     state_q;
  logic [7:0] sig_q;
  logic [7:0] thr_q;
  logic [7:0] seed_q;
  logic       mode_q;
  logic [7:0] cnt_q;
  logic [2:0] run_q;
  logic [7:0] exp_q;
  logic [7:0] res_q;
  logic       mis_q;
  logic       strt_q;
  logic       vld_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] first_d;
  logic [7:0] next_d;
  logic       gt_d;

  always_comb begin
    first_d = seed_q;
    if (!mode_q && seed_q == 8'd0) first_d = 8'h01;
    next_d = sig_q + 8'd1;
    if (!mode_q)
      next_d = {1'b0, sig_q[7:1]} ^ (sig_q[0] ? 8'hB8 : 8'h00);
    gt_d = sig_q > thr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      thr_q   <= '0;
      seed_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      run_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      mis_q   <= 1'b0;
      strt_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      strt_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q <= S_CAPT;
            thr_q   <= thresh;
            seed_q  <= seed;
            mode_q  <= mode;
            sig_q   <= thresh;
            strt_q  <= 1'b1;
            busy_q  <= 1'b1;
            exp_q   <= '0;
            run_q   <= '0;
          end
        end
        S_CAPT: begin
          state_q <= S_STREAM;
          sig_q   <= first_d;
          vld_q   <= 1'b1;
          cnt_q   <= '0;
        end
        S_STREAM: begin
          // Score the sample on the wire this cycle.
          if (gt_d) begin
            if (run_q != 3'd4) run_q <= run_q + 3'd1;
            if (run_q == 3'd3 && exp_q != 8'hFF) exp_q <= exp_q + 8'd1;
          end else begin
            run_q <= '0;
          end
          if (cnt_q == LEN_M1) begin
            state_q <= S_SETTLE;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            sig_q <= next_d;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SET_M1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            res_q   <= N_abv;
            mis_q   <= N_abv != exp_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sig        = sig_q;
  assign strtCapCmp = strt_q;
  assign sig_vld    = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = res_q;
  assign exp_cnt    = exp_q;
  assign mismatch   = mis_q;

endmodule

// File: tb/tb_sample_seq.sv
// tb_sample_seq: directed vector bench for sample_seq.
// Table-driven bursts plus reset-abort and back-to-back sequences.
module tb_sample_seq;

  logic       clk;
  logic       rst_n;
  logic       go;
  logic       mode;
  logic [7:0] thresh;
  logic [7:0] seed;
  logic [7:0] N_abv;
  logic [7:0] sig;
  logic       strtCapCmp;
  logic       sig_vld;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] exp_cnt;
  logic       mismatch;

  int n_run;
  int n_fail;

  sample_seq #(.LEN(16), .SETTLE(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .go(go),
    .mode(mode),
    .thresh(thresh),
    .seed(seed),
    .N_abv(N_abv),
    .sig(sig),
    .strtCapCmp(strtCapCmp),
    .sig_vld(sig_vld),
    .busy(busy),
    .done(done),
    .result(result),
    .exp_cnt(exp_cnt),
    .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] seed;
    logic [7:0] thresh;
    logic [7:0] nabv;
    logic       go_mid;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] slast;
    logic [7:0] exp;
    logic       mis;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic burst(input vec_t v);
    logic [7:0] samp[256];
    int vc;
    int strts;
    int busy_lo;
    int ramp_err;
    int done_at;
    vc = 0;
    strts = 0;
    busy_lo = 0;
    ramp_err = 0;
    done_at = -1;
    @(negedge clk);
    mode = v.mode;
    seed = v.seed;
    thresh = v.thresh;
    N_abv = v.nabv;
    go = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        go = 1'b0;
        chk("capt_sig", int'(sig), int'(v.thresh));
        chk("capt_vld", int'(sig_vld), 0);
      end
      if (v.go_mid && n == 4) go = 1'b1;
      if (n == 5) go = 1'b0;
      if (strtCapCmp) strts++;
      if (!busy) busy_lo++;
      if (sig_vld) begin
        if (vc < 256) samp[vc] = sig;
        if (v.mode && sig != 8'(v.seed + 8'(vc))) ramp_err++;
        vc++;
      end
      if (n == 18) begin
        chk("settle_sig", int'(sig), int'(v.slast));
        chk("settle_vld", int'(sig_vld), 0);
      end
      if (done) begin
        done_at = n;
        chk("exp_cnt", int'(exp_cnt), int'(v.exp));
        chk("result", int'(result), int'(v.nabv));
        chk("mismatch", int'(mismatch), int'(v.mis));
        break;
      end
    end
    chk("done_cycle", done_at, 20);
    chk("strt_cnt", strts, 1);
    chk("busy_low", busy_lo, 0);
    chk("vld_cnt", vc, 16);
    if (vc >= 2) begin
      chk("sample0", int'(samp[0]), int'(v.s0));
      chk("sample1", int'(samp[1]), int'(v.s1));
      chk("sample_last", int'(samp[vc-1]), int'(v.slast));
    end
    if (v.mode) chk("ramp_seq", ramp_err, 0);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("hold_result", int'(result), int'(v.nabv));
    chk("hold_exp", int'(exp_cnt), int'(v.exp));
    chk("hold_mis", int'(mismatch), int'(v.mis));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sig"}, int'(sig), 0);
    chk({tag, "_ctl"}, int'({strtCapCmp, sig_vld, busy, done, mismatch}), 0);
    chk({tag, "_res"}, int'(result), 0);
    chk({tag, "_exp"}, int'(exp_cnt), 0);
  endtask

  initial begin
    int strt_pos[$];
    int done_pos[$];
    int dones;
    n_run = 0;
    n_fail = 0;
    // mode seed thresh nabv go_mid s0 s1 slast exp mis
    vecs[0] = '{1'b1, 8'd0,   8'd10,  8'd1, 1'b0, 8'd0,   8'd1,   8'd15,  8'd1, 1'b0};
    vecs[1] = '{1'b1, 8'd250, 8'd200, 8'd1, 1'b0, 8'd250, 8'd251, 8'd9,   8'd1, 1'b0};
    vecs[2] = '{1'b1, 8'd0,   8'd255, 8'd3, 1'b0, 8'd0,   8'd1,   8'd15,  8'd0, 1'b1};
    vecs[3] = '{1'b0, 8'd0,   8'h20,  8'd2, 1'b1, 8'h01,  8'hB8,  8'h57,  8'd2, 1'b0};
    vecs[4] = '{1'b0, 8'h80,  8'h00,  8'd0, 1'b0, 8'h80,  8'h40,  8'h64,  8'd1, 1'b1};

    rst_n = 1'b0;
    go = 1'b0;
    mode = 1'b0;
    seed = '0;
    thresh = '0;
    N_abv = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) burst(vecs[i]);

    // Reset in the 5th stream cycle aborts the burst.
    @(negedge clk);
    mode = 1'b1;
    seed = 8'd0;
    thresh = 8'd10;
    N_abv = 8'd1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_vld", int'(sig_vld), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    burst(vecs[0]);

    // go held high: back-to-back bursts one IDLE cycle apart.
    @(negedge clk);
    mode = 1'b1;
    seed = 8'd0;
    thresh = 8'd10;
    N_abv = 8'd1;
    go = 1'b1;
    for (int n = 1; n <= 62; n++) begin
      @(negedge clk);
      if (strtCapCmp) strt_pos.push_back(n);
      if (done) done_pos.push_back(n);
    end
    go = 1'b0;
    chk("b2b_strts", strt_pos.size(), 3);
    chk("b2b_dones", done_pos.size(), 3);
    if (strt_pos.size() == 3) begin
      chk("b2b_strt1", strt_pos[1], 22);
      chk("b2b_strt2", strt_pos[2], 43);
    end
    if (done_pos.size() == 3) begin
      chk("b2b_done0", done_pos[0], 20);
      chk("b2b_done2", done_pos[2], 62);
    end
    repeat (25) @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
